latch_bank: RTL and testbench
=============================

# latch_bank

Clocked multi-channel successor to the team's single-word set/clear/gate latch. It holds CHANNELS independent WIDTH-bit words. Each word is updated only on the clock edge, through per-channel select with fixed clear > set > load priority. It adds an activity counter, a change pulse and an optional snapshot register, and sits between control software-visible strobes and downstream datapath configuration.

## Interface
- WIDTH, 4: bits per channel word (>=1)
- CHANNELS, 4: number of channel words (>=1)
- CNT_W, 8: width of saturating update counter (>=2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- sel  in  CHANNELS  multi-hot channel select; bit i targets channel i
- aclr  in  1  synchronous clear of selected channels
- aset  in  1  synchronous set (all ones) of selected channels
- gate  in  1  synchronous load of data into selected channels
- data  in  WIDTH  load value, broadcast to all selected channels
- snap  in  1  capture all channel words into shadow
- q  out  CHANNELS*WIDTH  channel words, channel i at bits [i*WIDTH +: WIDTH]
- q_snap  out  CHANNELS*WIDTH  shadow copy of q
- changed  out  1  one-cycle pulse: some channel value changed on the previous edge
- upd_cnt  out  CNT_W  saturating count of edges on which any channel value changed

## Operation
- Per selected channel, per edge: aclr=1 -> 0; else aset=1 -> all ones; else gate=1 -> data; else hold.
- Unselected channels always hold. When sel=0, all strobes are ignored.
- aclr and aset are synchronous. Only rst_n acts asynchronously.
- Change detect compares each channel's next value with its current value. "Changed" means a differing value, not merely a write: writing an identical value does not count.
- changed is registered: it goes high for exactly one cycle after a value-changing edge and stays high on consecutive change edges.
- upd_cnt increments by 1 on each value-changing edge and saturates at 2^CNT_W-1. It never wraps.
- snap=1 loads q_snap with the current q (the pre-edge value). A simultaneous write does not appear in q_snap until the next snap.
- Reset (rst_n=0, any time including mid-operation): q=0, q_snap=0, changed=0, upd_cnt=0, immediately and asynchronously. No operation is pending across reset.
- The first edge after rst_n deasserts is a normal operating edge.

## Timing
- Write latency: q reflects an accepted op one edge after the strobe is sampled.
- changed and upd_cnt update on the same edge as q.
- q_snap latency: one edge. It captures the value q held before that edge.
- All outputs are registered. There is no combinational input-to-output path.
- All strobes are level-sampled each edge; holding gate=1 reloads every cycle.

## Configuration
- LATCH_BANK_SNAP_EN defined: shadow register implemented; snap and q_snap behave as above.
- LATCH_BANK_SNAP_EN undefined: no shadow storage; snap ignored; q_snap tied to 0.
- Ports are identical in both builds.

## Structure
- Package latch_bank_pkg contains:
  - op enum: OP_HOLD, OP_LOAD, OP_SET, OP_CLR
  - priority-decode function (aclr, aset, gate, sel bit -> op)
  - default constants for WIDTH, CHANNELS, CNT_W
- Sub-module latch_bank_cell: one WIDTH-bit channel register with op input and a per-channel changed output.
- The top level generates CHANNELS instances and ORs the changed bits. The counter, change pulse and shadow stay in the top level.

## Test plan
- Reset, then CHANNELS=4, WIDTH=4, sel=4'b0101, gate=1, data=4'hA: ch0=ch2=4'hA, ch1=ch3=0. changed=1 for one cycle; upd_cnt=1.
- sel=4'b1111 with aclr=1, aset=1 and gate=1 all asserted: every channel becomes 0 (clear wins). Repeating the same cycle gives no change: changed=0 and upd_cnt unchanged.
- aset=1, sel=4'b0010: ch1=4'hF. Then reload ch1 with 4'hF via gate: changed=0, upd_cnt holds.
- With CNT_W=2, drive 5 value-changing edges: upd_cnt reads 1,2,3,3,3.
- With LATCH_BANK_SNAP_EN, q=16'h00A0 and snap=1 together with gate loading ch0=4'h5: q_snap=16'h00A0 and q=16'h00A5. A second snap gives q_snap=16'h00A5. Without the macro, q_snap=0 throughout.
- Assert rst_n=0 between clock edges mid-sequence: q, q_snap, changed and upd_cnt are 0 immediately, before the next edge.

Source files
------------

// File: rtl/latch_bank_pkg.sv
// Shared types and defaults for the latch_bank channel register bank.
// Holds the per-channel op encoding and the clear > set > load priority decode.
package latch_bank_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_CNT_W    = 8;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_SET,
    OP_CLR
  } op_e;

  function automatic op_e decode_op(input logic aclr, input logic aset,
                                    input logic gate, input logic sel_bit);
    op_e op;
    op = OP_HOLD;
    if (sel_bit) begin
      if (aclr)      op = OP_CLR;
      else if (aset) op = OP_SET;
      else if (gate) op = OP_LOAD;
    end
    return op;
  endfunction

endpackage

// File: rtl/latch_bank_cell.sv
// One WIDTH-bit channel register driven by a decoded op; latency one edge, no backpressure.
// o_chg is combinational: high when the pending op would alter the stored word.
module latch_bank_cell
  import latch_bank_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q,
  output logic             o_chg
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_nxt;

  always_comb begin
    w_nxt = r_q;
    case (i_op)
      OP_CLR:  w_nxt = '0;
      OP_SET:  w_nxt = '1;
      OP_LOAD: w_nxt = i_data;
      default: w_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= w_nxt;
  end

  assign o_q   = r_q;
  assign o_chg = (w_nxt != r_q);

endmodule

// File: rtl/latch_bank.sv
// Multi-channel set/clear/load register bank with change pulse, saturating update count and shadow.
// Latency one edge for q/changed/upd_cnt/q_snap; no backpressure. Shadow built only with LATCH_BANK_SNAP_EN.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       sel,
  input  logic                      aclr,
  input  logic                      aset,
  input  logic                      gate,
  input  logic [WIDTH-1:0]          data,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS*WIDTH-1:0] q_snap,
  output logic                      changed,
  output logic [CNT_W-1:0]          upd_cnt
);

  logic [CHANNELS*WIDTH-1:0] w_q;
  logic [CHANNELS-1:0]       w_chg;
  logic                      w_any_chg;
  logic                      r_changed;
  logic [CNT_W-1:0]          r_cnt;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    op_e w_op;
    assign w_op = decode_op(aclr, aset, gate, sel[i]);

    latch_bank_cell #(.WIDTH(WIDTH)) u_cell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_op   (w_op),
      .i_data (data),
      .o_q    (w_q[i*WIDTH +: WIDTH]),
      .o_chg  (w_chg[i])
    );
  end

  assign w_any_chg = |w_chg;

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_changed <= w_any_chg;
      if (w_any_chg && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef LATCH_BANK_SNAP_EN
  logic [CHANNELS*WIDTH-1:0] r_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_snap <= '0;
    else if (snap) r_snap <= w_q;
  end

  assign q_snap = r_snap;
`else
  logic w_unused_snap;
  assign w_unused_snap = snap;
  assign q_snap        = '0;
`endif

  assign q       = w_q;
  assign changed = r_changed;
  assign upd_cnt = r_cnt;

endmodule

// File: tb/tb_latch_bank.sv
// Directed bench for latch_bank: default instance plus a CNT_W=2 instance for counter saturation.
module tb_latch_bank;

`ifdef LATCH_BANK_SNAP_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  sel;
  logic        aclr, aset, gate, snap;
  logic [3:0]  data;

  logic [15:0] q, q_snap;
  logic        changed;
  logic [7:0]  upd_cnt;

  logic [15:0] q_b, q_snap_b;
  logic        changed_b;
  logic [1:0]  upd_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  latch_bank #(.WIDTH(4), .CHANNELS(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .aclr(aclr), .aset(aset), .gate(gate),
    .data(data), .snap(snap), .q(q), .q_snap(q_snap), .changed(changed), .upd_cnt(upd_cnt)
  );

  latch_bank #(.WIDTH(4), .CHANNELS(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .sel(sel), .aclr(aclr), .aset(aset), .gate(gate),
    .data(data), .snap(snap), .q(q_b), .q_snap(q_snap_b), .changed(changed_b), .upd_cnt(upd_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] s, input logic c, input logic st,
                       input logic g, input logic [3:0] d, input logic sn);
    sel = s; aclr = c; aset = st; gate = g; data = d; snap = sn;
  endtask

  task automatic chk_main(input string tag, input logic [15:0] eq,
                          input logic ec, input logic [7:0] ecnt);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_chg"}, 32'(changed), 32'(ec));
    chk({tag, "_cnt"}, 32'(upd_cnt), 32'(ecnt));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    #3;
    chk_main("rst", 16'h0000, 1'b0, 8'd0);
    chk("rst_snap", 32'(q_snap), 32'h0);
    chk("rst_cnt_b", 32'(upd_cnt_b), 32'h0);
    #9 rst_n = 1'b1;

    // First edge after release is a normal write.
    drive(4'b0101, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0);
    tick();
    chk_main("load", 16'h0A0A, 1'b1, 8'd1);

    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    tick();
    chk_main("idle", 16'h0A0A, 1'b0, 8'd1);

    drive(4'b1111, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0);
    tick();
    chk_main("clrwin", 16'h0000, 1'b1, 8'd2);
    tick();
    chk_main("clrrep", 16'h0000, 1'b0, 8'd2);

    drive(4'b0000, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0);
    tick();
    chk_main("sel0", 16'h0000, 1'b0, 8'd2);

    drive(4'b0010, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    tick();
    chk_main("set1", 16'h00F0, 1'b1, 8'd3);

    drive(4'b0010, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    tick();
    chk_main("sameld", 16'h00F0, 1'b0, 8'd3);

    drive(4'b0010, 1'b0, 1'b0, 1'b1, 4'hA, 1'b0);
    tick();
    chk_main("ld1A", 16'h00A0, 1'b1, 8'd4);

    drive(4'b0001, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
    tick();
    chk_main("snapwr", 16'h00A5, 1'b1, 8'd5);
    chk("snap1", 32'(q_snap), SNAP ? 32'h00A0 : 32'h0);

    // Held gate with same data reloads without counting a change.
    drive(4'b0001, 1'b0, 1'b0, 1'b1, 4'h5, 1'b1);
    tick();
    chk_main("snap2st", 16'h00A5, 1'b0, 8'd5);
    chk("snap2", 32'(q_snap), SNAP ? 32'h00A5 : 32'h0);

    drive(4'b1111, 1'b0, 1'b0, 1'b1, 4'h3, 1'b0);
    tick();
    chk_main("ldall", 16'h3333, 1'b1, 8'd6);

    drive(4'b0000, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_main("arst", 16'h0000, 1'b0, 8'd0);
    chk("arst_snap", 32'(q_snap), 32'h0);
    chk("arst_q_b", 32'(q_b), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    chk_main("postrst", 16'h0000, 1'b0, 8'd0);

    for (int i = 1; i <= 5; i++) begin
      drive(4'b0001, 1'b0, 1'b0, 1'b1, 4'(i), 1'b0);
      tick();
      chk($sformatf("sat_cnt%0d", i), 32'(upd_cnt_b), (i < 3) ? 32'(i) : 32'd3);
      chk($sformatf("sat_chg%0d", i), 32'(changed_b), 32'd1);
      chk($sformatf("wide_cnt%0d", i), 32'(upd_cnt), 32'(i));
      chk($sformatf("sat_q%0d", i), 32'(q_b), 32'(i));
    end
    chk("sat_snap", 32'(q_snap_b), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
